// File: rtl/bch_serial_parity_encoder.sv
// Systematic serial BCH encoder: passes message bits straight through while folding them into the
// parity LFSR, then shifts the parity out MSB first and rearms for the next codeword.
module bch_serial_parity_encoder #(
    parameter int unsigned MessageLength = 4096,
    parameter int unsigned ParityLength  = 168,
    // Default generator; instantiate with the released t=12 GF(2^14) polynomial for production.
    parameter logic [ParityLength-1:0] GenPoly =
        ParityLength'(168'h4B_1D3C_97A2_E60F_58C4_B31A_7D92_0E6F_C85B_27D1_3A95)
) (
    input  logic iClock,
    input  logic iReset,
    input  logic iMessageBit,
    input  logic iMessageValid,
    output logic oMessageReady,
    output logic oCodeBit,
    output logic oCodeValid,
    input  logic iCodeReady,
    output logic oCodeLast,
    output logic oBusy
);

    localparam int unsigned CountWidth = 14;
    localparam logic [CountWidth-1:0] MsgLastCount = CountWidth'(MessageLength - 1);
    localparam logic [CountWidth-1:0] ParLastCount = CountWidth'(ParityLength - 1);

    typedef enum logic {
        ST_MSG,
        ST_PARITY
    } state_e;

    state_e                  state_q, state_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic [ParityLength-1:0] parity_q, parity_d;
    logic                    fb;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= ST_MSG;
            count_q  <= '0;
            parity_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            parity_q <= parity_d;
        end
    end

    // Next-state and handshake logic; reset forces every output low.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        parity_d      = parity_q;
        oMessageReady = 1'b0;
        oCodeBit      = 1'b0;
        oCodeValid    = 1'b0;
        oCodeLast     = 1'b0;
        fb            = iMessageBit ^ parity_q[ParityLength-1];

        unique case (state_q)
            ST_MSG: begin
                oMessageReady = iCodeReady;
                oCodeBit      = iMessageBit;
                oCodeValid    = iMessageValid;
                if (iMessageValid && iCodeReady) begin
                    parity_d    = (parity_q << 1) ^ (GenPoly & {ParityLength{fb}});
                    parity_d[0] = fb;
                    if (count_q == MsgLastCount) begin
                        state_d = ST_PARITY;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CountWidth'(1);
                    end
                end
            end
            ST_PARITY: begin
                oCodeValid = 1'b1;
                oCodeBit   = parity_q[ParityLength-1];
                oCodeLast  = (count_q == ParLastCount);
                if (iCodeReady) begin
                    // Shifting out leaves the register all-zero after the last bit.
                    parity_d = parity_q << 1;
                    if (count_q == ParLastCount) begin
                        state_d = ST_MSG;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CountWidth'(1);
                    end
                end
            end
            default: begin
                state_d = ST_MSG;
            end
        endcase

        oBusy = (count_q != '0) || (state_q == ST_PARITY);

        if (iReset) begin
            oMessageReady = 1'b0;
            oCodeBit      = 1'b0;
            oCodeValid    = 1'b0;
            oCodeLast     = 1'b0;
            oBusy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_bch_serial_parity_encoder.sv
// Bench for bch_serial_parity_encoder: full-size stream tests against a polynomial-division model
// plus an 8-bit build checked with a vector table and an exhaustive message sweep.
module tb_bch_serial_parity_encoder;

    localparam int unsigned MsgLen = 4096;
    localparam int unsigned ParLen = 168;
    localparam int unsigned CwLen  = MsgLen + ParLen;
    localparam logic [167:0] Gen   = 168'h4B_1D3C_97A2_E60F_58C4_B31A_7D92_0E6F_C85B_27D1_3A95;
    localparam logic [7:0]   SGen  = 8'h1D;

    typedef bit bitq_t[$];
    typedef struct {
        logic [7:0] msg;
        logic [7:0] par;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, m_bit, m_valid, m_ready, c_bit, c_valid, c_ready, c_last, busy;
    logic s_bit, s_valid, s_mready, s_cbit, s_cvalid, s_cready, s_last, s_busy;

    bch_serial_parity_encoder #(
        .MessageLength(MsgLen), .ParityLength(ParLen), .GenPoly(Gen)
    ) dut (
        .iClock(clk), .iReset(rst), .iMessageBit(m_bit), .iMessageValid(m_valid),
        .oMessageReady(m_ready), .oCodeBit(c_bit), .oCodeValid(c_valid),
        .iCodeReady(c_ready), .oCodeLast(c_last), .oBusy(busy)
    );

    bch_serial_parity_encoder #(
        .MessageLength(8), .ParityLength(8), .GenPoly(SGen)
    ) dut_small (
        .iClock(clk), .iReset(rst), .iMessageBit(s_bit), .iMessageValid(s_valid),
        .oMessageReady(s_mready), .oCodeBit(s_cbit), .oCodeValid(s_cvalid),
        .iCodeReady(s_cready), .oCodeLast(s_last), .oBusy(s_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Remainder of m(x)*x^p divided by g(x) by long division; first message bit is highest degree.
    function automatic void bch_parity(input bitq_t msg, input int p, input logic [167:0] gen,
                                       output bitq_t par);
        bit d[$];
        d = msg;
        for (int j = 0; j < p; j++) d.push_back(1'b0);
        for (int k = 0; k < msg.size(); k++)
            if (d[k]) for (int j = 1; j <= p; j++) d[k+j] = d[k+j] ^ gen[p-j];
        par = {};
        for (int j = 0; j < p; j++) par.push_back(d[msg.size()+j]);
    endfunction

    bitq_t exp_q, got_q;
    int    exp_last[$], got_last[$];
    int    cyc = 0, n_xfer = 0, first_x = -1, last_x = -1, pos = 0, busy_miss = 0;

    // Observe the main DUT's code stream at the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("reset_outputs", 64'({m_ready, c_valid, c_last, busy, c_bit}), 64'd0);
        end else if (c_valid && c_ready) begin
            if (pos > 0 && busy !== 1'b1) busy_miss++;
            got_q.push_back(c_bit);
            if (c_last) got_last.push_back(got_q.size());
            n_xfer++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            pos = c_last ? 0 : pos + 1;
        end
    end

    task automatic clear_streams();
        exp_q = {}; got_q = {}; exp_last = {}; got_last = {};
        n_xfer = 0; first_x = -1; last_x = -1; pos = 0; busy_miss = 0;
    endtask

    task automatic rand_msg(output bitq_t m);
        m = {};
        for (int i = 0; i < MsgLen; i++) m.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic add_frame(input bitq_t m);
        bitq_t p;
        bch_parity(m, ParLen, Gen, p);
        foreach (m[i]) exp_q.push_back(m[i]);
        foreach (p[i]) exp_q.push_back(p[i]);
        exp_last.push_back(exp_q.size());
    endtask

    // Present msgs in order under the chosen Valid/Ready patterns until all expected bits arrive.
    task automatic stream(input bitq_t msgs, input bit rand_valid, input bit toggle_ready,
                          input int budget);
        int idx = 0;
        int t = 0;
        bit rdy = 1'b1;
        while ((idx < msgs.size() || got_q.size() < exp_q.size()) && t < budget) begin
            if (idx < msgs.size()) begin
                m_bit   = msgs[idx];
                m_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                m_bit   = 1'b0;
                m_valid = 1'b0;
            end
            c_ready = toggle_ready ? rdy : 1'b1;
            rdy = ~rdy;
            @(negedge clk);
            if (m_valid && m_ready) idx++;
            @(posedge clk);
            #1;
            t++;
        end
        check("stream_in_budget", 64'(t < budget), 64'd1);
        m_valid = 1'b0;
        c_ready = 1'b1;
    endtask

    task automatic check_stream();
        int mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] != exp_q[i]) mism++;
        check("stream_len", 64'(got_q.size()), 64'(exp_q.size()));
        check("stream_bits", 64'(mism), 64'd0);
        check("last_count", 64'(got_last.size()), 64'(exp_last.size()));
        for (int i = 0; i < exp_last.size() && i < got_last.size(); i++)
            check("last_pos", 64'(got_last[i]), 64'(exp_last[i]));
        check("busy_in_frame", 64'(busy_miss), 64'd0);
    endtask

    task automatic small_frame(input logic [7:0] msg, output logic [15:0] cw, output int last_pos);
        int n = 0;
        int t = 0;
        cw = '0;
        last_pos = -1;
        s_cready = 1'b1;
        while (n < 16 && t < 64) begin
            s_valid = (n < 8);
            s_bit   = (n < 8) ? msg[7-n] : 1'b0;
            @(negedge clk);
            if (s_cvalid && s_cready) begin
                cw = {cw[14:0], s_cbit};
                if (s_last) last_pos = n + 1;
                n++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        bitq_t       m, all, f, p;
        logic [15:0] cw;
        logic [7:0]  exp_par;
        int          lp, mism;

        tbl[0] = '{msg: 8'h00, par: 8'h00};
        tbl[1] = '{msg: 8'h01, par: 8'h1D};
        tbl[2] = '{msg: 8'h02, par: 8'h3A};
        tbl[3] = '{msg: 8'h03, par: 8'h27};
        tbl[4] = '{msg: 8'h10, par: 8'hCD};
        tbl[5] = '{msg: 8'h80, par: 8'h26};
        tbl[6] = '{msg: 8'hFF, par: 8'hC4};

        rst = 1'b1; m_bit = 1'b0; m_valid = 1'b0; c_ready = 1'b1;
        s_bit = 1'b0; s_valid = 1'b0; s_cready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ready_follows", 64'(m_ready), 64'd1);
        check("idle_code_valid", 64'(c_valid), 64'd0);
        @(posedge clk);
        #1;

        // All-zero message at full rate.
        clear_streams();
        m = {};
        for (int i = 0; i < MsgLen; i++) m.push_back(1'b0);
        add_frame(m);
        stream(m, 1'b0, 1'b0, CwLen + 50);
        check_stream();
        check("zero_last_at", 64'(got_last.size() > 0 ? got_last[0] : -1), 64'(CwLen));
        check("zero_busy_after", 64'(busy), 64'd0);

        // Single trailing one: parity equals the generator, MSB first.
        clear_streams();
        m = {};
        for (int i = 0; i < MsgLen - 1; i++) m.push_back(1'b0);
        m.push_back(1'b1);
        add_frame(m);
        stream(m, 1'b0, 1'b0, CwLen + 50);
        check_stream();
        mism = 0;
        for (int j = 0; j < ParLen; j++)
            if (got_q.size() < CwLen || got_q[MsgLen+j] != Gen[ParLen-1-j]) mism++;
        check("impulse_is_genpoly", 64'(mism), 64'd0);

        // Random frame with random Valid and Ready toggling every cycle.
        clear_streams();
        rand_msg(m);
        add_frame(m);
        stream(m, 1'b1, 1'b1, 30000);
        check_stream();

        // Reset after 100 message bits, then a fresh frame.
        clear_streams();
        for (int i = 0; i < 100; i++) begin
            m_bit = 1'($urandom_range(0, 1));
            m_valid = 1'b1;
            c_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        m_valid = 1'b0;
        check("busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b1;
        m_valid = 1'b1;
        @(negedge clk);
        check("reset_forces_zero", 64'({m_ready, c_valid, c_last, busy, c_bit}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        check("busy_after_reset", 64'(busy), 64'd0);
        clear_streams();
        rand_msg(m);
        add_frame(m);
        stream(m, 1'b0, 1'b0, CwLen + 50);
        check_stream();

        // Three frames back-to-back at full rate.
        clear_streams();
        all = {};
        for (int k = 0; k < 3; k++) begin
            rand_msg(f);
            add_frame(f);
            foreach (f[i]) all.push_back(f[i]);
        end
        stream(all, 1'b0, 1'b0, 3 * CwLen + 50);
        check_stream();
        check("b2b_xfers", 64'(n_xfer), 64'(3 * CwLen));
        check("b2b_no_idle", 64'(last_x - first_x + 1), 64'(3 * CwLen));
        for (int k = 0; k < 3; k++)
            check("b2b_last_at", 64'(k < got_last.size() ? got_last[k] : -1), 64'((k + 1) * CwLen));

        // 8-bit build: hand-computed vectors.
        for (int i = 0; i < 7; i++) begin
            small_frame(tbl[i].msg, cw, lp);
            check("small_tbl_msg", 64'(cw[15:8]), 64'(tbl[i].msg));
            check("small_tbl_par", 64'(cw[7:0]), 64'(tbl[i].par));
            check("small_tbl_last", 64'(lp), 64'd16);
        end

        // 8-bit build: exhaustive sweep against the division model.
        for (int v = 0; v < 256; v++) begin
            m = {};
            for (int i = 7; i >= 0; i--) m.push_back(v[i]);
            bch_parity(m, 8, 168'(SGen), p);
            exp_par = '0;
            foreach (p[i]) exp_par = {exp_par[6:0], p[i]};
            small_frame(8'(v), cw, lp);
            check("small_sweep", 64'(cw), 64'({8'(v), exp_par}));
        end
        check("small_busy_idle", 64'(s_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
